// File: rtl/os_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// os_ctrl_pkg : shared constants for the output-stationary instruction sequencer
//   (inst bus field map, idle instruction word, sequencer state encoding).
// Rev 1.0
// ============================================================================
package os_ctrl_pkg;

    localparam int INST_W       = 40;
    localparam int ADDR_W       = 8;

    localparam int CEN_PMEM_BIT = 37;
    localparam int WEN_PMEM_BIT = 36;
    localparam int CEN1_BIT     = 26;
    localparam int A1_LSB       = 18;
    localparam int CEN0_BIT     = 17;
    localparam int WEN0_BIT     = 16;
    localparam int A0_LSB       = 8;
    localparam int OFIFO_RD_BIT = 7;
    localparam int IFIFO_WR_BIT = 6;
    localparam int IFIFO_RD_BIT = 5;
    localparam int L0_RD_BIT    = 4;
    localparam int L0_WR_BIT    = 3;
    localparam int MODE_BIT     = 2;
    localparam int EXECUTE_BIT  = 1;
    localparam int LOAD_BIT     = 0;

    localparam int FLUSH_CYCLES = 2;

    // All memories deselected / write-disabled, every strobe low
    localparam logic [INST_W-1:0] INST_IDLE = (INST_W'(1) << CEN_PMEM_BIT)
                                            | (INST_W'(1) << WEN_PMEM_BIT)
                                            | (INST_W'(1) << CEN1_BIT)
                                            | (INST_W'(1) << CEN0_BIT)
                                            | (INST_W'(1) << WEN0_BIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_FLUSH = 3'd2,
        S_SHIFT = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/os_inst_sequencer_if.sv
`default_nettype none
// ============================================================================
// os_inst_sequencer_if : host start/done handshake, core readiness and inst bus
// Rev 1.0
// ============================================================================
interface os_inst_sequencer_if #(
    parameter int LEN_W = 8
);
    logic                           start;
    logic [LEN_W-1:0]               len_nij;
    logic                           l0_ready;
    logic                           ififo_ready;
    logic                           ofifo_valid;
    logic [os_ctrl_pkg::INST_W-1:0] inst;
    logic                           busy;
    logic                           done;

    modport master (
        output start, len_nij, l0_ready, ififo_ready, ofifo_valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, len_nij, l0_ready, ififo_ready, ofifo_valid,
        output inst, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/os_strobe_pipe.sv
`default_nettype none
// ============================================================================
// os_strobe_pipe : delays the issue pulse into write (+1) and read/execute (+2)
// Rev 1.0
// ============================================================================
module os_strobe_pipe (
    input  logic clk,
    input  logic reset_n,
    input  logic issue_i,
    output logic wr_o,
    output logic rd_o
);
    logic [1:0] pipe_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[0], issue_i};
        end
    end

    assign wr_o = pipe_q[0];
    assign rd_o = pipe_q[1];
endmodule
`default_nettype wire

// File: rtl/os_inst_sequencer.sv
`default_nettype none
// ============================================================================
// os_inst_sequencer : generates the core inst word for one run
//   (SRAM reads -> L0/IFIFO, execute, shift out, OFIFO drain).
// Rev 1.0
// ============================================================================
module os_inst_sequencer
    import os_ctrl_pkg::*;
#(
    parameter int          COL          = 8,
    parameter int          LEN_W        = 8,
    parameter logic [7:0]  X_BASE       = 8'h00,
    parameter logic [7:0]  W_BASE       = 8'h80,
    parameter int          SHIFT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    os_inst_sequencer_if.slave bus
);
    localparam int SHIFT_W = $clog2(SHIFT_CYCLES + 1);
    localparam int COL_W   = $clog2(COL + 1);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [SHIFT_W-1:0]  phase_cnt_q, phase_cnt_d;
    logic [COL_W-1:0]    rd_left_q, rd_left_d;
    logic                issue_q, issue_d;
    logic [ADDR_W-1:0]   a0_q, a0_d;
    logic [ADDR_W-1:0]   a1_q, a1_d;
    logic                mode_q, mode_d;
    logic                load_q, load_d;
    logic                ofifo_rd_q, ofifo_rd_d;
    logic                wr_stb;
    logic                rd_stb;
    logic [INST_W-1:0]   inst_asm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            phase_cnt_q <= '0;
            rd_left_q   <= '0;
            issue_q     <= 1'b0;
            a0_q        <= '0;
            a1_q        <= '0;
            mode_q      <= 1'b0;
            load_q      <= 1'b0;
            ofifo_rd_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            phase_cnt_q <= phase_cnt_d;
            rd_left_q   <= rd_left_d;
            issue_q     <= issue_d;
            a0_q        <= a0_d;
            a1_q        <= a1_d;
            mode_q      <= mode_d;
            load_q      <= load_d;
            ofifo_rd_q  <= ofifo_rd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        phase_cnt_d = phase_cnt_q;
        rd_left_d   = rd_left_q;
        issue_d     = 1'b0;
        ofifo_rd_d  = 1'b0;
        a0_d        = a0_q;
        a1_d        = a1_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.len_nij != '0) begin
                        len_d   = bus.len_nij;
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (cnt_q == len_q) begin
                    phase_cnt_d = '0;
                    state_d     = S_FLUSH;
                end else if (bus.l0_ready && bus.ififo_ready) begin
                    issue_d = 1'b1;
                    a0_d    = X_BASE + ADDR_W'(cnt_q);
                    a1_d    = W_BASE + ADDR_W'(cnt_q);
                    cnt_d   = cnt_q + LEN_W'(1);
                end
            end
            S_FLUSH: begin
                if (phase_cnt_q == SHIFT_W'(FLUSH_CYCLES - 1)) begin
                    phase_cnt_d = '0;
                    state_d     = S_SHIFT;
                end else begin
                    phase_cnt_d = phase_cnt_q + SHIFT_W'(1);
                end
            end
            S_SHIFT: begin
                if (phase_cnt_q == SHIFT_W'(SHIFT_CYCLES - 1)) begin
                    rd_left_d = COL_W'(COL);
                    state_d   = S_DRAIN;
                end else begin
                    phase_cnt_d = phase_cnt_q + SHIFT_W'(1);
                end
            end
            S_DRAIN: begin
                // A read is only launched when the previous cycle had none,
                // giving the OFIFO a cycle to update its valid flag.
                if (rd_left_q == '0) begin
                    state_d = S_DONE;
                end else if (bus.ofifo_valid && !ofifo_rd_q) begin
                    ofifo_rd_d = 1'b1;
                    rd_left_d  = rd_left_q - COL_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered mode/load follow the next state so they line up with it
        mode_d = (state_d == S_SHIFT) || (state_d == S_DRAIN);
        load_d = (state_d == S_SHIFT);
        if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
            a0_d = '0;
            a1_d = '0;
        end
    end

    os_strobe_pipe u_strobe_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .issue_i (issue_q),
        .wr_o    (wr_stb),
        .rd_o    (rd_stb)
    );

    always_comb begin
        inst_asm                     = INST_IDLE;
        inst_asm[CEN0_BIT]           = ~issue_q;
        inst_asm[CEN1_BIT]           = ~issue_q;
        inst_asm[A0_LSB +: ADDR_W]   = a0_q;
        inst_asm[A1_LSB +: ADDR_W]   = a1_q;
        inst_asm[OFIFO_RD_BIT]       = ofifo_rd_q;
        inst_asm[IFIFO_WR_BIT]       = wr_stb;
        inst_asm[L0_WR_BIT]          = wr_stb;
        inst_asm[IFIFO_RD_BIT]       = rd_stb;
        inst_asm[L0_RD_BIT]          = rd_stb;
        inst_asm[EXECUTE_BIT]        = rd_stb;
        inst_asm[MODE_BIT]           = mode_q | rd_stb;
        inst_asm[LOAD_BIT]           = load_q;
    end

    assign bus.inst = inst_asm;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_os_inst_sequencer.sv
`default_nettype none
// ============================================================================
// tb_os_inst_sequencer : directed self-checking bench for os_inst_sequencer
// Rev 1.0
// ============================================================================
module tb_os_inst_sequencer;

    localparam logic [39:0] IDLE_WORD = 40'h30_0403_0000;

    logic clk = 1'b0;
    logic reset_n;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    os_inst_sequencer_if #(.LEN_W(8)) bus ();

    os_inst_sequencer #(
        .COL          (8),
        .LEN_W        (8),
        .X_BASE       (8'h00),
        .W_BASE       (8'h80),
        .SHIFT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] mk_inst(input bit iss, input logic [7:0] a0, input logic [7:0] a1,
                                            input bit wr, input bit rd, input bit mode,
                                            input bit load, input bit ofrd);
        logic [39:0] v;
        v        = IDLE_WORD;
        v[26]    = ~iss;
        v[25:18] = a1;
        v[17]    = ~iss;
        v[15:8]  = a0;
        v[7]     = ofrd;
        v[6]     = wr;
        v[5]     = rd;
        v[4]     = rd;
        v[3]     = wr;
        v[2]     = mode;
        v[1]     = rd;
        v[0]     = load;
        return v;
    endfunction

    function automatic bit bit_at(input logic [31:0] m, input int i);
        if (i >= 0 && i < 32) return m[i];
        return 1'b0;
    endfunction

    // One full run with len_nij=4. iss_mask marks the cycles (after start) on
    // which the inst bus should show an SRAM read; n_last is the final one.
    task automatic run_case(input string name, input logic [31:0] iss_mask, input int n_last,
                            input int gap_start, input int gap_len, input bit alt_valid,
                            input int busy_start);
        int          load_cnt;
        int          rd_cnt;
        int          b2b;
        int          idx;
        bit          prev_rd;
        bit          exp_load;
        bit          exp_rd;
        bit          exp_mode;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [39:0] exp_inst;
        load_cnt = 0;
        rd_cnt   = 0;
        b2b      = 0;
        prev_rd  = 1'b0;

        @(negedge clk);
        bus.start   = 1'b1;
        bus.len_nij = 8'd4;
        for (int c = 1; c <= n_last + 36; c++) begin
            @(negedge clk);
            idx = -1;
            for (int k = 1; k <= c && k < 32; k++) begin
                if (iss_mask[k]) idx++;
            end
            a0       = (idx < 0) ? 8'h00 : 8'(idx);
            a1       = (idx < 0) ? 8'h00 : 8'h80 + 8'(idx);
            exp_load = (c >= n_last + 3) && (c <= n_last + 18);
            exp_rd   = (c >= n_last + 20) && (c <= n_last + 34) && (((c - n_last) % 2) == 0);
            exp_mode = bit_at(iss_mask, c - 2) || exp_load || ((c >= n_last + 19) && (c <= n_last + 34));
            if (c >= n_last + 35)
                exp_inst = IDLE_WORD;
            else
                exp_inst = mk_inst(bit_at(iss_mask, c), a0, a1, bit_at(iss_mask, c - 1),
                                   bit_at(iss_mask, c - 2), exp_mode, exp_load, exp_rd);
            check_val($sformatf("%s inst c%0d", name, c), bus.inst, exp_inst);
            check_val($sformatf("%s busy c%0d", name, c), {39'b0, bus.busy}, {39'b0, (c <= n_last + 35)});
            check_val($sformatf("%s done c%0d", name, c), {39'b0, bus.done}, {39'b0, (c == n_last + 35)});
            load_cnt += int'(bus.inst[0]);
            if (bus.inst[7]) begin
                rd_cnt++;
                if (prev_rd) b2b++;
            end
            prev_rd = bus.inst[7];

            bus.start = (c == busy_start);
            if (c == busy_start) bus.len_nij = 8'd2;
            bus.l0_ready = !((c >= gap_start) && (c < gap_start + gap_len));
            // valid is held high through SHIFT where it must be ignored
            if (c >= n_last + 35)
                bus.ofifo_valid = 1'b0;
            else if (c >= n_last + 19)
                bus.ofifo_valid = !(alt_valid && (c == n_last + 20));
            else
                bus.ofifo_valid = (c >= n_last + 3);
        end
        check_val({name, " load count"}, 40'(load_cnt), 40'd16);
        check_val({name, " ofifo_rd count"}, 40'(rd_cnt), 40'd8);
        check_val({name, " back-to-back rd"}, 40'(b2b), 40'd0);
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.len_nij     = 8'd0;
        bus.l0_ready    = 1'b1;
        bus.ififo_ready = 1'b1;
        bus.ofifo_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset inst", bus.inst, IDLE_WORD);
        check_val("reset busy", {39'b0, bus.busy}, 40'd0);
        check_val("reset done", {39'b0, bus.done}, 40'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("post-reset inst", bus.inst, IDLE_WORD);

        // Async reset in the middle of ISSUE, two of four reads issued
        bus.start   = 1'b1;
        bus.len_nij = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("t1 A0 before reset", {32'b0, bus.inst[15:8]}, 40'h01);
        check_val("t1 CEN0 before reset", {39'b0, bus.inst[17]}, 40'd0);
        #2 reset_n = 1'b0;
        #1;
        check_val("t1 async inst", bus.inst, IDLE_WORD);
        check_val("t1 async busy", {39'b0, bus.busy}, 40'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("t1 released inst", bus.inst, IDLE_WORD);
        check_val("t1 released busy", {39'b0, bus.busy}, 40'd0);

        // Back-to-back reads, readies tied high, valid always high in DRAIN
        run_case("t2", 32'h0000_003C, 5, 1000, 0, 1'b0, 0);

        // l0_ready low 3 cycles after second read, start retried while busy,
        // valid pattern 1,0,1,1,...
        run_case("t3", 32'h0000_018C, 8, 3, 3, 1'b1, 4);

        // Zero-length run finishes without touching the SRAMs
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len_nij = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("t6 done", {39'b0, bus.done}, 40'd1);
        check_val("t6 inst c1", bus.inst, IDLE_WORD);
        @(negedge clk);
        check_val("t6 done cleared", {39'b0, bus.done}, 40'd0);
        check_val("t6 busy cleared", {39'b0, bus.busy}, 40'd0);
        check_val("t6 inst c2", bus.inst, IDLE_WORD);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
